// File: rtl/cpu_mem_bridge_pkg.sv
// Shared definitions for the CPU-to-SoC-bus memory bridge.
package cpu_mem_bridge_pkg;

    typedef enum logic [1:0] {
        BRIDGE_IDLE = 2'd0,
        BRIDGE_REQ  = 2'd1,
        BRIDGE_RESP = 2'd2
    } bridge_state_e;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/cpu_mem_bridge_bus_watchdog.sv
// Cycle counter that flags a bus request left unanswered for TIMEOUT_CYCLES cycles.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_WIDTH      = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam bit                   LP_ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] LP_LAST   =
        LP_ENABLE ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_at_last;

    assign w_at_last = (r_cnt == LP_LAST);

    // Counter parks on the last value so expiry stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = LP_ENABLE & w_at_last;

endmodule

// File: rtl/cpu_mem_bridge.sv
// Registers one CPU memory request onto a valid/ready bus and returns the
// slave response (or a watchdog access fault) as a one-cycle ready pulse.
module cpu_mem_bridge
    import cpu_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_WIDTH      = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_fault,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    bridge_state_e r_state;
    bridge_state_e w_next;
    logic          w_accept;
    logic          w_wait;
    logic          w_expired;

    assign w_accept = (r_state == BRIDGE_IDLE) && cpu_valid;
    assign w_wait   = (r_state == BRIDGE_REQ) && !bus_ready;

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (w_accept),
        .run     (w_wait),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= BRIDGE_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            BRIDGE_IDLE: if (cpu_valid) w_next = BRIDGE_REQ;
            BRIDGE_REQ:  if (bus_ready || w_expired) w_next = BRIDGE_RESP;
            BRIDGE_RESP: w_next = BRIDGE_IDLE;
            default:     w_next = BRIDGE_IDLE;
        endcase
    end

    always_comb begin
        bus_valid = (r_state == BRIDGE_REQ);
        cpu_ready = (r_state == BRIDGE_RESP);
    end

    // bus_ready is tested before expiry so a same-cycle answer completes normally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            cpu_rdata <= '0;
            cpu_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                bus_addr  <= cpu_addr;
                bus_wdata <= cpu_wdata;
                bus_wstrb <= cpu_wstrb;
            end
            if (r_state == BRIDGE_REQ) begin
                if (bus_ready) begin
                    cpu_rdata <= bus_rdata;
                    cpu_fault <= 1'b0;
                end else if (w_expired) begin
                    cpu_rdata <= '0;
                    cpu_fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: vector table driver plus a
// completion scoreboard, with hand-written reset-abort sequence.
module tb_cpu_mem_bridge;
    import cpu_mem_bridge_pkg::*;

    localparam int unsigned TMO = 8;

    logic        clk;
    logic        resetn;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    cpu_mem_bridge #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_fault (cpu_fault),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] slave_rdata;
        bit          noise;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_cycles;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   total;
    int   bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after RESP.
    task automatic txn(input vec_t v);
        exp_t e;
        int   n;
        e.rdata = v.exp_rdata;
        e.fault = v.exp_fault;
        sb.push_back(e);
        cpu_valid = 1'b1;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_wstrb = v.wstrb;
        @(negedge clk);
        n = 0;
        while (cpu_ready !== 1'b1 && n < 40) begin
            chk({v.name, "/bus_valid"}, 32'(bus_valid), 32'd1);
            chk({v.name, "/bus_addr"},  bus_addr,  v.addr);
            chk({v.name, "/bus_wdata"}, bus_wdata, v.wdata);
            chk({v.name, "/bus_wstrb"}, 32'(bus_wstrb), 32'(v.wstrb));
            bus_ready = (n == v.waits);
            bus_rdata = bus_ready ? v.slave_rdata : (32'hBAD0_0000 + 32'(n));
            if (v.noise) begin
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
                cpu_wstrb = 4'($urandom);
            end
            @(negedge clk);
            n++;
        end
        bus_ready = 1'b0;
        cpu_valid = 1'b0;
        chk({v.name, "/req_cycles"}, 32'(n), 32'(v.exp_cycles));
        chk({v.name, "/resp_bus_valid"}, 32'(bus_valid), 32'd0);
        @(negedge clk);
        chk({v.name, "/ready_pulse"}, 32'(cpu_ready), 32'd0);
        chk({v.name, "/rdata_held"}, cpu_rdata, v.exp_rdata);
        chk({v.name, "/fault_held"}, 32'(cpu_fault), 32'(v.exp_fault));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{"read0",   32'h8000_0010, 32'h0,         WSTRB_READ, 0,    32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[1] = '{"write5",  32'h1000_0004, 32'h1234_5678, 4'b0011,    5,    32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0, 6};
        vecs[2] = '{"timeout", 32'h2000_0000, 32'h0,         4'b1111,    1000, 32'h1111_2222, 1'b0, 32'h0,         1'b1, 8};
        vecs[3] = '{"tie",     32'h3000_0008, 32'h0,         WSTRB_READ, 7,    32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 8};
        vecs[4] = '{"b2b_a",   32'h4000_0000, 32'h1111_1111, 4'b1111,    2,    32'h0000_0042, 1'b1, 32'h0000_0042, 1'b0, 3};
        vecs[5] = '{"b2b_b",   32'h4000_0100, 32'h2222_2222, 4'b0100,    1,    32'h7777_8888, 1'b0, 32'h7777_8888, 1'b0, 2};
        vecs[6] = '{"read6",   32'h5000_0000, 32'h0,         WSTRB_READ, 6,    32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0, 7};

        resetn    = 1'b0;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (cpu_ready === 1'b1) begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL spurious_ready: got cpu_ready=1 expected no completion at %0t", $time);
                        end else begin
                            e = sb.pop_front();
                            chk("sb_rdata", cpu_rdata, e.rdata);
                            chk("sb_fault", 32'(cpu_fault), 32'(e.fault));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst/cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst/cpu_rdata", cpu_rdata, 32'd0);
        chk("rst/cpu_fault", 32'(cpu_fault), 32'd0);
        chk("rst/bus_valid", 32'(bus_valid), 32'd0);
        chk("rst/bus_addr",  bus_addr, 32'd0);
        chk("rst/bus_wdata", bus_wdata, 32'd0);
        chk("rst/bus_wstrb", 32'(bus_wstrb), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            txn(vecs[i]);
        end

        // Abandon a request at wait-state 3 with a one-cycle reset.
        cpu_valid = 1'b1;
        cpu_addr  = 32'h6000_0000;
        cpu_wdata = 32'h9999_0000;
        cpu_wstrb = 4'b1000;
        @(negedge clk);
        for (int n = 0; n < 3; n++) @(negedge clk);
        chk("abort/bus_valid_pre", 32'(bus_valid), 32'd1);
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("abort/bus_valid", 32'(bus_valid), 32'd0);
        chk("abort/cpu_ready", 32'(cpu_ready), 32'd0);
        chk("abort/cpu_rdata", cpu_rdata, 32'd0);
        chk("abort/cpu_fault", 32'(cpu_fault), 32'd0);
        chk("abort/bus_addr",  bus_addr, 32'd0);
        chk("abort/bus_wdata", bus_wdata, 32'd0);
        chk("abort/bus_wstrb", 32'(bus_wstrb), 32'd0);
        resetn = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("abort/no_ready", 32'(cpu_ready), 32'd0);
            chk("abort/idle_bus", 32'(bus_valid), 32'd0);
        end
        txn(vecs[0]);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
